// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: data width, FSM state type and the
// round-robin winner search used by rr_arbiter.
package adder_arb_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } arbState_e;

   // Search starts one past the last winner and wraps modulo numReq.
   function automatic logic [2:0] next_rr(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         last,
                                          input int unsigned        numReq);
      logic [2:0] winner;
      logic [2:0] idx;
      logic       found;
      winner = '0;
      found  = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         idx = 3'((32'(last) + k) % numReq);
         if (!found && (k <= numReq) && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      return winner;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Round-robin grant logic: one-hot grant plus index for the first valid
// requester after last_grant, gated by enable.
module rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    last_grant,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   always_comb begin
      grant_idx = ID_W'(next_rr(MAX_REQ'(req_valid), 3'(last_grant), NUM_REQ));
      grant     = '0;
      if (enable && (|req_valid)) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 8-bit adder among NUM_REQ requesters via round-robin arbitration.
// Optional macro ADDER_ARB_SATURATE_EN clamps overflowing sums to 0xFF.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic [DATA_W-1:0]         resp_sum,
   output logic                      resp_carry
);

   arbState_e         state_q, state_d;
   logic [ID_W-1:0]   lastGrant_q, lastGrant_d;
   logic [ID_W-1:0]   capId_q, capId_d;
   logic [DATA_W-1:0] opA_q, opA_d;
   logic [DATA_W-1:0] opB_q, opB_d;
   logic [ID_W-1:0]   respId_q, respId_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              carry_q, carry_d;

   logic [NUM_REQ-1:0] grantVec;
   logic [ID_W-1:0]    grantIdx;
   logic               arbEnable;
   logic [DATA_W:0]    rawSum;

   assign arbEnable = (state_q == IDLE);
   assign rawSum    = {1'b0, opA_q} + {1'b0, opB_q};

   rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
      .req_valid  (req_valid),
      .last_grant (lastGrant_q),
      .enable     (arbEnable),
      .grant      (grantVec),
      .grant_idx  (grantIdx)
   );

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      capId_d     = capId_q;
      opA_d       = opA_q;
      opB_d       = opB_q;
      respId_d    = respId_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      req_ready   = '0;
      case (state_q)
         IDLE: begin
            if (|grantVec) begin
               req_ready = grantVec;
               opA_d     = req_a[grantIdx*DATA_W +: DATA_W];
               opB_d     = req_b[grantIdx*DATA_W +: DATA_W];
               capId_d   = grantIdx;
               state_d   = CALC;
            end
         end
         CALC: begin
            // Result registers only change here, so RESP outputs stay frozen.
            respId_d    = capId_q;
`ifdef ADDER_ARB_SATURATE_EN
            sum_d       = rawSum[DATA_W] ? '1 : rawSum[DATA_W-1:0];
`else
            sum_d       = rawSum[DATA_W-1:0];
`endif
            carry_d     = rawSum[DATA_W];
            lastGrant_d = capId_q;
            state_d     = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // lastGrant resets to the top index so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= ID_W'(NUM_REQ - 1);
         capId_q     <= '0;
         opA_q       <= '0;
         opB_q       <= '0;
         respId_q    <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         capId_q     <= capId_d;
         opA_q       <= opA_d;
         opB_q       <= opB_d;
         respId_q    <= respId_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
      end
   end

   assign resp_valid = (state_q == RESP);
   assign resp_id    = respId_q;
   assign resp_sum   = sum_q;
   assign resp_carry = carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: transaction-level model checked every
// cycle, plus directed tests with hand-computed expectations.
module tb_adder_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = $clog2(NUM_REQ);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*8-1:0] req_a = '0;
   logic [NUM_REQ*8-1:0] req_b = '0;
   logic                 resp_valid;
   logic                 resp_ready = 1'b1;
   logic [ID_W-1:0]      resp_id;
   logic [7:0]           resp_sum;
   logic                 resp_carry;

   adder_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_carry (resp_carry)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int id; } grantRec_t;
   typedef struct { int cyc; int id; int sum; int carry; } respRec_t;

   grantRec_t grantLog[$];
   respRec_t  respLog[$];

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   bit mBusy = 1'b0;
   bit mFresh = 1'b1;
   int mAge = 0, mLast = NUM_REQ - 1;
   int mId = 0, mSum = 0, mCarry = 0;
   int pId = 0, pSum = 0, pCarry = 0;

   logic [NUM_REQ-1:0] readySeen = '0;
   logic [NUM_REQ-1:0] prevValid = '0;
   logic [NUM_REQ-1:0] prevReady = '0;

   int         pendCnt[NUM_REQ] = '{default: 0};
   logic [7:0] opA[NUM_REQ]     = '{default: 8'h00};
   logic [7:0] opB[NUM_REQ]     = '{default: 8'h00};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic int rrPick(input logic [NUM_REQ-1:0] v, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic int modelSum(input int a, input int b);
      int s;
      s = a + b;
`ifdef ADDER_ARB_SATURATE_EN
      return (s > 255) ? 255 : s;
`else
      return s % 256;
`endif
   endfunction

   // Per-cycle compare against the transaction model, sampled on the falling edge.
   always @(negedge clk) begin
      int                 win;
      int                 gi;
      int                 a;
      int                 b;
      logic [NUM_REQ-1:0] expReady;
      bit                 expValid;
      cycle++;
      if (rst) begin
         checkOutput("rst_req_ready", 32'(req_ready), 0);
         checkOutput("rst_resp_valid", 32'(resp_valid), 0);
         checkOutput("rst_resp_id", 32'(resp_id), 0);
         checkOutput("rst_resp_sum", 32'(resp_sum), 0);
         checkOutput("rst_resp_carry", 32'(resp_carry), 0);
         mBusy = 1'b0; mAge = 0; mLast = NUM_REQ - 1;
         mId = 0; mSum = 0; mCarry = 0; mFresh = 1'b1;
         readySeen = '0; prevValid = '0; prevReady = '0;
      end else begin
         win      = rrPick(req_valid, mLast);
         expReady = (!mBusy && win >= 0) ? (NUM_REQ'(1) << win) : '0;
         expValid = mBusy && (mAge >= 2);
         checkOutput("req_ready", 32'(req_ready), 32'(expReady));
         checkOutput("resp_valid", 32'(resp_valid), 32'(expValid));
         if (expValid || mFresh) begin
            checkOutput("resp_id", 32'(resp_id), mId);
            checkOutput("resp_sum", 32'(resp_sum), mSum);
            checkOutput("resp_carry", 32'(resp_carry), mCarry);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (prevValid[i] && !prevReady[i]) checkOutput("hold_valid", 32'(req_valid[i]), 1);
         end
         if (req_ready != '0) begin
            gi = -1;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gi = i;
            grantLog.push_back('{cyc: cycle, id: gi});
         end
         if (resp_valid && resp_ready) begin
            respLog.push_back('{cyc: cycle, id: int'(resp_id), sum: int'(resp_sum), carry: int'(resp_carry)});
         end
         if (!mBusy) begin
            if (win >= 0) begin
               a = int'(req_a[win*8 +: 8]);
               b = int'(req_b[win*8 +: 8]);
               mBusy = 1'b1; mAge = 1; mLast = win;
               pId = win; pSum = modelSum(a, b); pCarry = (a + b > 255) ? 1 : 0;
            end
         end else if (mAge == 1) begin
            mAge = 2; mId = pId; mSum = pSum; mCarry = pCarry; mFresh = 1'b0;
         end else if (resp_ready) begin
            mBusy = 1'b0;
         end
         readySeen = req_ready;
         prevValid = req_valid;
         prevReady = req_ready;
      end
   end

   // Requester behaviour: keep valid and operands up until granted pendCnt times.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (readySeen[i] && pendCnt[i] > 0) pendCnt[i]--;
         req_valid[i]     = (pendCnt[i] > 0);
         req_a[i*8 +: 8]  = opA[i];
         req_b[i*8 +: 8]  = opB[i];
      end
   end

   task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] b, input int n);
      opA[i]     = a;
      opB[i]     = b;
      pendCnt[i] = n;
   endtask

   task automatic setRespReady(input logic v);
      @(posedge clk);
      #2;
      resp_ready = v;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic waitGrants(input int n, input int budget);
      int k = 0;
      while (grantLog.size() < n && k < budget) begin waitCycles(1); k++; end
      if (grantLog.size() < n) checkOutput("grant_timeout", 32'(grantLog.size()), 32'(n));
   endtask

   task automatic waitResps(input int n, input int budget);
      int k = 0;
      while (respLog.size() < n && k < budget) begin waitCycles(1); k++; end
      if (respLog.size() < n) checkOutput("resp_timeout", 32'(respLog.size()), 32'(n));
   endtask

   task automatic checkGrant(input string tag, input int g, input int id);
      if (grantLog.size() > g) checkOutput(tag, 32'(grantLog[g].id), 32'(id));
   endtask

   task automatic checkResp(input string tag, input int r, input int id, input int sum, input int carry);
      if (respLog.size() > r) begin
         checkOutput({tag, "_id"}, 32'(respLog[r].id), 32'(id));
         checkOutput({tag, "_sum"}, 32'(respLog[r].sum), 32'(sum));
         checkOutput({tag, "_carry"}, 32'(respLog[r].carry), 32'(carry));
      end
   endtask

   task automatic checkAsyncReset(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(req_ready), 0);
      checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 0);
      checkOutput({tag, "_resp_id"}, 32'(resp_id), 0);
      checkOutput({tag, "_resp_sum"}, 32'(resp_sum), 0);
      checkOutput({tag, "_resp_carry"}, 32'(resp_carry), 0);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g;
      int r;
      int k;
      int expOrder[6];
      expOrder = '{0, 1, 2, 3, 0, 1};

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1 checkAsyncReset("post_reset");

      // Single request from requester 0.
      waitCycles(1);
      g = grantLog.size(); r = respLog.size();
      applyStimulus(0, 8'h12, 8'h34, 1);
      waitResps(r + 1, 20);
      checkGrant("single_gid", g, 0);
      checkResp("single", r, 0, 'h46, 0);
      if (respLog.size() > r && grantLog.size() > g)
         checkOutput("single_latency", 32'(respLog[r].cyc - grantLog[g].cyc), 2);

      // Overflow cases; last grant ends on requester 3.
      g = grantLog.size(); r = respLog.size();
      applyStimulus(1, 8'hFF, 8'h01, 1);
      waitResps(r + 1, 20);
      checkGrant("ovf1_gid", g, 1);
`ifdef ADDER_ARB_SATURATE_EN
      checkResp("ovf1", r, 1, 'hFF, 1);
`else
      checkResp("ovf1", r, 1, 'h00, 1);
`endif
      g = grantLog.size(); r = respLog.size();
      applyStimulus(3, 8'h80, 8'h90, 1);
      waitResps(r + 1, 20);
      checkGrant("ovf2_gid", g, 3);
`ifdef ADDER_ARB_SATURATE_EN
      checkResp("ovf2", r, 3, 'hFF, 1);
`else
      checkResp("ovf2", r, 3, 'h10, 1);
`endif

      // Fairness: all four held valid, starting after a grant to 3.
      g = grantLog.size(); r = respLog.size();
      applyStimulus(0, 8'h01, 8'h01, 2);
      applyStimulus(1, 8'h02, 8'h02, 2);
      applyStimulus(2, 8'h03, 8'h03, 1);
      applyStimulus(3, 8'h04, 8'h04, 1);
      waitResps(r + 6, 60);
      for (int i = 0; i < 6; i++) begin
         checkGrant("rr_order", g + i, expOrder[i]);
         if (i > 0 && grantLog.size() > g + i)
            checkOutput("rr_spacing", 32'(grantLog[g+i].cyc - grantLog[g+i-1].cyc), 3);
      end
      checkResp("rr0", r, 0, 'h02, 0);
      checkResp("rr1", r + 1, 1, 'h04, 0);

      // Back-pressure with requester 2 waiting.
      setRespReady(1'b0);
      waitCycles(1);
      g = grantLog.size(); r = respLog.size();
      applyStimulus(0, 8'h01, 8'h02, 1);
      waitGrants(g + 1, 20);
      applyStimulus(2, 8'h05, 8'h06, 1);
      k = 0;
      while (!resp_valid && k < 10) begin waitCycles(1); k++; end
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", 32'(resp_valid), 1);
         checkOutput("bp_sum", 32'(resp_sum), 'h03);
         checkOutput("bp_id", 32'(resp_id), 0);
         checkOutput("bp_ready", 32'(req_ready), 0);
         waitCycles(1);
      end
      setRespReady(1'b1);
      waitGrants(g + 2, 20);
      checkGrant("bp_gid", g + 1, 2);
      if (grantLog.size() > g + 1 && respLog.size() > r)
         checkOutput("bp_regrant_cycle", 32'(grantLog[g+1].cyc - respLog[r].cyc), 1);
      waitResps(r + 2, 20);
      checkResp("bp2", r + 1, 2, 'h0B, 0);

      // Reset mid-CALC discards the transaction.
      waitCycles(1);
      g = grantLog.size(); r = respLog.size();
      applyStimulus(0, 8'h10, 8'h20, 1);
      waitGrants(g + 1, 20);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 checkAsyncReset("async_reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      waitCycles(6);
      checkOutput("rst_no_resp", 32'(respLog.size()), 32'(r));

      // Wrap and skip: last grant is 3 after reset.
      g = grantLog.size(); r = respLog.size();
      applyStimulus(2, 8'h07, 8'h08, 1);
      waitGrants(g + 1, 20);
      applyStimulus(0, 8'h11, 8'h22, 1);
      applyStimulus(3, 8'h33, 8'h44, 1);
      waitGrants(g + 3, 30);
      checkGrant("wrap_g0", g, 2);
      checkGrant("wrap_g1", g + 1, 3);
      checkGrant("wrap_g2", g + 2, 0);
      waitResps(r + 3, 30);
      checkResp("wrap3", r + 1, 3, 'h77, 0);
      waitCycles(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
